dac_pulse_driver: RTL and testbench
===================================

Name: dac_pulse_driver

Overview:
- Transmit-side counterpart of the ADC capture path: drives the 128-bit AXIS sample stream into the RFSoC DAC (8 x 16-bit signed samples per word, sample 0 in bits 15:0).
- Two sources: single-word pulses built from 8-bit values issued by the experiment FSM, and arbitrary waveforms loaded by the PS over DMA into a local buffer, then played back on a GPIO-register trigger.

Parameters:
- DEPTH, 1024, waveform buffer depth in 128-bit words (power of 2).
- CFG_BASE_ADDR, 512, GPIO base address; CTRL at +0, SHIFT at +1, PULSE_POS at +2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- gpio_in  in  32  GPIO config bus: [15:0] addr, [23:16] data, [24] w_clk
- val_in  in  8  signed pulse amplitude from FSM
- val_valid  in  1  one-cycle strobe qualifying val_in
- s_axis_tdata  in  128  waveform words from PS DMA
- s_axis_tvalid  in  1  DMA word valid
- s_axis_tlast  in  1  last word of waveform
- s_axis_tready  out  1  buffer accepting
- m_axis_tdata  out  128  samples to DAC
- m_axis_tvalid  out  1  always 1 out of reset
- m_axis_tready  in  1  DAC ready
- play_busy  out  1  high in PLAY
- play_done  out  1  one-cycle pulse at end of playback

Behaviour:
- Reset: m_axis_tdata=0, m_axis_tvalid=0 during reset and 1 from the first clock after release, s_axis_tready=0, play_busy=0, play_done=0, wave length LEN=0, all config registers 0, state IDLE.
- GPIO writes:
  - gpio_in is synchronised with 2 flops; a write occurs on the synchronised rising edge of bit 24 when addr matches.
  - CTRL bit0 = TRIG, bit1 = LOAD_EN, bit2 = LOOP.
  - SHIFT[3:0]: values above 8 are treated as 8.
  - PULSE_POS[2:0].
- Output register:
  - m_axis_tdata is registered and advances only on cycles with m_axis_tready=1; otherwise it holds.
  - Idle word is all zeros.
- States IDLE, LOAD, PLAY, DONE:
  - IDLE -> LOAD on LOAD_EN rising edge. Write pointer and LEN are cleared. LOAD has priority over a simultaneous TRIG edge, which is discarded.
  - IDLE -> PLAY on TRIG rising edge with LEN>0.
  - IDLE -> DONE on TRIG rising edge with LEN=0; play_done pulses on the next cycle and no data is emitted.
  - LOAD: s_axis_tready=1 while wr_ptr<DEPTH. Each accepted word is written at wr_ptr, then wr_ptr and LEN increment. Accepting tlast, or LOAD_EN falling, -> IDLE. When full, tready=0 and the block stays in LOAD until tlast or LOAD_EN falls; extra words are not accepted.
  - PLAY:
    - Buffer RAM has 1-cycle registered read.
    - First word reaches m_axis_tdata 2 cycles after the TRIG edge is detected, given tready=1.
    - Words 0..LEN-1 are emitted in order; under backpressure no word is dropped or duplicated.
    - A stall holds both the read address and the read data.
    - After word LEN-1 is accepted: -> DONE, play_done pulses for 1 cycle, output returns to zero.
  - DONE -> IDLE when TRIG reads 0.
- Pulses (IDLE only):
  - On val_valid, the next output word has sample[PULSE_POS] = sign_extend16(val_in) <<< SHIFT and all other samples 0, for exactly one accepted transfer, then returns to zero.
  - If tready=0, the pulse is held until accepted. A second val_valid while a pulse is pending overwrites it.
  - val_valid in LOAD, PLAY or DONE is ignored.
- Mid-operation:
  - Reset mid-PLAY or mid-LOAD returns everything to reset values. Buffer contents become undefined; LEN=0.
  - Clearing TRIG during PLAY does not abort playback.

Optional Feature:
- Macro DAC_PLAY_LOOP_EN.
- Defined: with CTRL.LOOP=1, PLAY wraps from word LEN-1 back to word 0 with no gap cycle. Loop playback ends when TRIG reads 0 at the wrap point, and play_done pulses then.
- Undefined: the LOOP bit is ignored; playback is single-shot.

Decomposition:
- Package dac_pkg: state enum, CTRL bit indices, register offsets, SAMPLE_W=16, SAMPLES_PER_WORD=8.
- Config registers reuse the existing config_reg module.
- One sub-module, dac_wave_mem: simple dual-port RAM, DEPTH x 128, with registered read and a read-enable input for stalls.

Test Plan:
- Reset, then idle 10 cycles -> m_axis_tdata=0, m_axis_tvalid=1, s_axis_tready=0, play_busy=0.
- SHIFT=4, PULSE_POS=3, val_in=0x85 strobed -> next word has bits[63:48]=0xF850 and all else 0, for one cycle, then zeros.
- LOAD_EN=1, send 4 words A,B,C,D with tlast on D, LOAD_EN=0, then TRIG=1 -> A,B,C,D on consecutive cycles, play_done pulses once, then zeros.
- Same playback with m_axis_tready toggled every cycle -> exactly A,B,C,D are accepted, with no repeats or gaps.
- DEPTH=16, 20 words sent without tlast -> 16 accepted, s_axis_tready=0 afterward; playback emits 16 words.
- After reset (LEN=0), TRIG=1 -> play_done pulse, no non-zero output; SHIFT=12 with val_in=0x7F -> sample=0x7F00.

Source files
------------

// File: rtl/dac_pkg.sv
// dac_pkg: shared types, register map and sample-format helpers for the DAC pulse driver
package dac_pkg;
   localparam int SAMPLE_W         = 16;
   localparam int SAMPLES_PER_WORD = 8;
   localparam int WORD_W           = SAMPLE_W * SAMPLES_PER_WORD;
   localparam int CTRL_TRIG        = 0;
   localparam int CTRL_LOAD_EN     = 1;
   localparam int CTRL_LOOP        = 2;
   localparam int REG_CTRL         = 0;
   localparam int REG_SHIFT        = 1;
   localparam int REG_PULSE_POS    = 2;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_DONE} state_t;
   // one-hot-sample word: sign-extended amplitude, shifted (capped at 8), placed in lane pos
   function automatic logic [WORD_W-1:0] pulse_word(input logic [7:0] val, input logic [3:0] shift,
                                                    input logic [2:0] pos);
      logic [SAMPLE_W-1:0] s;
      s = {{8{val[7]}}, val} << ((shift > 4'd8) ? 4'd8 : shift);
      return WORD_W'(s) << {pos, 4'b0000};
   endfunction
endpackage

// File: rtl/dac_pulse_driver_if.sv
// dac_pulse_driver_if: 128-bit AXI-Stream link with master/slave views
interface dac_pulse_driver_if import dac_pkg::*; ();
   logic [WORD_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;
   modport master (output tdata, tvalid, tlast, input tready);
   modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/config_reg.sv
// config_reg: single GPIO-addressed configuration register
module config_reg #(
   parameter logic [15:0] ADDR = 16'd0,
   parameter int          W    = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_wr,
   input  logic [15:0]  i_addr,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_q;
   // capture the data field on a write strobe addressed to this register
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_q <= '0;
      else if (i_wr && i_addr == ADDR) r_q <= i_data;
   assign o_q = r_q;
endmodule

// File: rtl/dac_wave_mem.sv
// dac_wave_mem: simple dual-port waveform RAM with registered, enable-gated read
module dac_wave_mem import dac_pkg::*; #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [WORD_W-1:0] o_rdata
);
   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rdata;
   // write port
   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   // read port holds its data whenever the enable is low so stalls keep the word
   always_ff @(posedge clk)
      if (i_re) r_rdata <= r_mem[i_raddr];
   assign o_rdata = r_rdata;
endmodule

// File: rtl/dac_pulse_driver.sv
// dac_pulse_driver: drives DAC sample stream from FSM pulses or a DMA-loaded waveform (DAC_PLAY_LOOP_EN enables looped playback)
module dac_pulse_driver import dac_pkg::*; #(
   parameter int DEPTH         = 1024,
   parameter int CFG_BASE_ADDR = 512
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        gpio_in,
   input  logic [7:0]         val_in,
   input  logic               val_valid,
   dac_pulse_driver_if.slave  s_axis,
   dac_pulse_driver_if.master m_axis,
   output logic               play_busy,
   output logic               play_done
);
   localparam int AW = $clog2(DEPTH);
   state_t            r_state, w_next;
   logic [31:0]       r_gpio_s1, r_gpio_s2;
   logic              r_wclk_d, w_gpio_wr;
   logic [2:0]        w_ctrl, w_pos;
   logic [3:0]        w_shift;
   logic              r_trig_d, r_load_d, w_trig, w_load_en;
   logic              w_trig_rise, w_load_rise, w_load_fall, w_wrap, w_unused;
   logic [AW:0]       r_len;
   logic              w_s_rdy, w_s_acc, w_idle, w_start, w_issue, w_at_end;
   logic              r_iss, r_rd_vld, r_rd_last, r_out_last;
   logic [AW-1:0]     r_rd_addr, w_rd_addr;
   logic [WORD_W-1:0] w_rd_data, r_tdata, r_pword, w_pword;
   logic              r_pend, w_pend, w_val, r_tvalid, r_done;

   // two-flop synchroniser for the GPIO bus plus w_clk history for write-edge detection
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_gpio_s1 <= '0;
         r_gpio_s2 <= '0;
         r_wclk_d  <= 1'b0;
      end else begin
         r_gpio_s1 <= gpio_in;
         r_gpio_s2 <= r_gpio_s1;
         r_wclk_d  <= r_gpio_s2[24];
      end
   assign w_gpio_wr = r_gpio_s2[24] & ~r_wclk_d;

   config_reg #(.ADDR(16'(CFG_BASE_ADDR + REG_CTRL)), .W(3)) u_ctrl (
      .clk(clk), .rst(rst), .i_wr(w_gpio_wr), .i_addr(r_gpio_s2[15:0]),
      .i_data(r_gpio_s2[18:16]), .o_q(w_ctrl));
   config_reg #(.ADDR(16'(CFG_BASE_ADDR + REG_SHIFT)), .W(4)) u_shift (
      .clk(clk), .rst(rst), .i_wr(w_gpio_wr), .i_addr(r_gpio_s2[15:0]),
      .i_data(r_gpio_s2[19:16]), .o_q(w_shift));
   config_reg #(.ADDR(16'(CFG_BASE_ADDR + REG_PULSE_POS)), .W(3)) u_pos (
      .clk(clk), .rst(rst), .i_wr(w_gpio_wr), .i_addr(r_gpio_s2[15:0]),
      .i_data(r_gpio_s2[18:16]), .o_q(w_pos));

   assign w_trig    = w_ctrl[CTRL_TRIG];
   assign w_load_en = w_ctrl[CTRL_LOAD_EN];
`ifdef DAC_PLAY_LOOP_EN
   assign w_wrap   = w_ctrl[CTRL_LOOP] & w_trig;
   assign w_unused = ^{r_gpio_s2[31:25], r_gpio_s2[23:20]};
`else
   assign w_wrap   = 1'b0;
   assign w_unused = ^{r_gpio_s2[31:25], r_gpio_s2[23:20], w_ctrl[CTRL_LOOP]};
`endif

   // previous TRIG / LOAD_EN values for edge detection
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_trig_d <= 1'b0;
         r_load_d <= 1'b0;
      end else begin
         r_trig_d <= w_trig;
         r_load_d <= w_load_en;
      end
   assign w_trig_rise = w_trig & ~r_trig_d;
   assign w_load_rise = w_load_en & ~r_load_d;
   assign w_load_fall = ~w_load_en & r_load_d;

   assign w_idle  = r_state == ST_IDLE;
   assign w_s_rdy = (r_state == ST_LOAD) & ~r_len[AW];
   assign w_s_acc = w_s_rdy & s_axis.tvalid;
   assign w_start = w_idle & w_trig_rise & ~w_load_rise & (r_len != '0);

   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= ST_IDLE;
      else r_state <= w_next;

   // next-state logic; LOAD_EN edge wins over a simultaneous TRIG edge
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: w_next = w_load_rise ? ST_LOAD :
                           w_trig_rise ? ((r_len != '0) ? ST_PLAY : ST_DONE) : ST_IDLE;
         ST_LOAD: w_next = ((w_s_acc && s_axis.tlast) || w_load_fall) ? ST_IDLE : ST_LOAD;
         ST_PLAY: w_next = (m_axis.tready && r_out_last) ? ST_DONE : ST_PLAY;
         ST_DONE: w_next = w_trig ? ST_DONE : ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // waveform length doubles as the write pointer; cleared on entry to LOAD
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_len <= '0;
      else if (w_idle && w_load_rise) r_len <= '0;
      else if (w_s_acc) r_len <= r_len + (AW+1)'(1);

   dac_wave_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk(clk), .i_we(w_s_acc), .i_waddr(r_len[AW-1:0]), .i_wdata(s_axis.tdata),
      .i_re(w_issue), .i_raddr(w_rd_addr), .o_rdata(w_rd_data));

   assign w_rd_addr = w_start ? '0 : r_rd_addr;
   assign w_issue   = m_axis.tready & (w_start | ((r_state == ST_PLAY) & r_iss));
   assign w_at_end  = {1'b0, w_rd_addr} == r_len - (AW+1)'(1);

   // read issue: first read goes out in the trigger cycle so the word lands two cycles later
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_iss     <= 1'b0;
         r_rd_addr <= '0;
      end else if (w_issue) begin
         r_iss     <= ~w_at_end | w_wrap;
         r_rd_addr <= w_at_end ? '0 : w_rd_addr + AW'(1);
      end else if (w_start) begin
         r_iss     <= 1'b1;
         r_rd_addr <= '0;
      end

   // read-data stage tracking; moves only with the DAC so stalls hold address and data
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_rd_vld  <= 1'b0;
         r_rd_last <= 1'b0;
      end else if (m_axis.tready) begin
         r_rd_vld  <= w_issue;
         r_rd_last <= w_issue & w_at_end & ~w_wrap;
      end

   assign w_val   = val_valid & w_idle;
   assign w_pend  = w_val | (r_pend & w_idle);
   assign w_pword = w_val ? pulse_word(val_in, w_shift, w_pos) : r_pword;

   // pending pulse: newest strobe wins until the output register takes it
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_pend  <= 1'b0;
         r_pword <= '0;
      end else begin
         r_pend  <= w_pend & ~m_axis.tready;
         r_pword <= w_pword;
      end

   // output register: playback word, else pulse, else zero; advances only on accepted transfers
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_tdata    <= '0;
         r_out_last <= 1'b0;
         r_tvalid   <= 1'b0;
      end else begin
         r_tvalid <= 1'b1;
         if (m_axis.tready) begin
            r_tdata    <= r_rd_vld ? w_rd_data : w_pend ? w_pword : '0;
            r_out_last <= r_rd_vld & r_rd_last;
         end
      end

   // single-cycle completion pulse on entry to DONE
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_done <= 1'b0;
      else r_done <= (w_next == ST_DONE) & (r_state != ST_DONE);

   assign s_axis.tready = w_s_rdy;
   assign m_axis.tdata  = r_tdata;
   assign m_axis.tvalid = r_tvalid;
   assign m_axis.tlast  = 1'b0;
   assign play_busy     = r_state == ST_PLAY;
   assign play_done     = r_done;
endmodule

// File: tb/tb_dac_pulse_driver.sv
// tb_dac_pulse_driver: directed-vector bench for dac_pulse_driver (DEPTH=16)
module tb_dac_pulse_driver;
   import dac_pkg::*;
   logic         clk = 1'b0, rst = 1'b0;
   logic [31:0]  gpio_in = '0;
   logic [7:0]   val_in = '0;
   logic         val_valid = 1'b0;
   logic         play_busy, play_done;
   int           n_vec = 0, n_err = 0;
   logic [127:0] got[$];
   int           dones, first_c, last_c;
   bit           busy_seen;

   dac_pulse_driver_if s_if();
   dac_pulse_driver_if m_if();

   dac_pulse_driver #(.DEPTH(16), .CFG_BASE_ADDR(512)) dut (
      .clk(clk), .rst(rst), .gpio_in(gpio_in), .val_in(val_in), .val_valid(val_valid),
      .s_axis(s_if), .m_axis(m_if), .play_busy(play_busy), .play_done(play_done));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic gpio_write(input logic [15:0] addr, input logic [7:0] data);
      gpio_in = {8'h00, data, addr};
      tick;
      gpio_in[24] = 1'b1;
      tick;
      tick;
      gpio_in[24] = 1'b0;
   endtask

   task automatic strobe(input logic [7:0] v);
      val_in = v;
      val_valid = 1'b1;
      tick;
      val_valid = 1'b0;
   endtask

   task automatic send(input logic [127:0] d, input bit last, input int tmo, output bit ok);
      s_if.tdata = d;
      s_if.tlast = last;
      s_if.tvalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < tmo && !ok; i++) begin
         ok = s_if.tready;
         tick;
      end
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
   endtask

   task automatic capture(input int ncyc, input bit toggle);
      got.delete();
      dones = 0;
      first_c = -1;
      last_c = -1;
      busy_seen = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         if (toggle) m_if.tready = c[0];
         if (m_if.tready && m_if.tdata != '0) begin
            got.push_back(m_if.tdata);
            if (first_c < 0) first_c = c;
            last_c = c;
         end
         if (play_done) dones++;
         if (play_busy) busy_seen = 1'b1;
         tick;
      end
      m_if.tready = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid_in_reset: got %b expected 0", m_if.tvalid); end
      n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL rst_tdata_in_reset: got %h expected 0", m_if.tdata); end
      rst = 1'b1;
      repeat (10) tick;
      n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL idle_tdata: got %h expected 0", m_if.tdata); end
      n_vec++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL idle_tvalid: got %b expected 1", m_if.tvalid); end
      n_vec++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL idle_s_tready: got %b expected 0", s_if.tready); end
      n_vec++; if (play_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", play_busy); end
      n_vec++; if (play_done !== 1'b0) begin n_err++; $display("FAIL idle_done: got %b expected 0", play_done); end
   endtask

   task automatic test_pulse;
      logic [127:0] exp_a, exp_b;
      exp_a = '0;
      exp_a[63:48] = 16'hF850;
      exp_b = '0;
      exp_b[63:48] = 16'h0010;
      gpio_write(16'd513, 8'd4);
      gpio_write(16'd514, 8'd3);
      repeat (4) tick;
      strobe(8'h85);
      n_vec++; if (m_if.tdata !== exp_a) begin n_err++; $display("FAIL pulse_word: got %h expected %h", m_if.tdata, exp_a); end
      tick;
      n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL pulse_return_zero: got %h expected 0", m_if.tdata); end
      m_if.tready = 1'b0;
      strobe(8'h85);
      strobe(8'h01);
      tick;
      n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL pulse_stalled_hold: got %h expected 0", m_if.tdata); end
      m_if.tready = 1'b1;
      tick;
      n_vec++; if (m_if.tdata !== exp_b) begin n_err++; $display("FAIL pulse_overwrite: got %h expected %h", m_if.tdata, exp_b); end
      m_if.tready = 1'b0;
      tick;
      n_vec++; if (m_if.tdata !== exp_b) begin n_err++; $display("FAIL pulse_held_unaccepted: got %h expected %h", m_if.tdata, exp_b); end
      m_if.tready = 1'b1;
      tick;
      n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL pulse_once: got %h expected 0", m_if.tdata); end
   endtask

   task automatic check_play(input logic [127:0] exp_w [4], input bit consec, input string tag);
      n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL %s_count: got %0d expected 4", tag, got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_vec++; if (got[i] !== exp_w[i]) begin n_err++; $display("FAIL %s_word%0d: got %h expected %h", tag, i, got[i], exp_w[i]); end
      end
      n_vec++; if (dones != 1) begin n_err++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, dones); end
      n_vec++; if (!busy_seen) begin n_err++; $display("FAIL %s_busy: got 0 expected 1", tag); end
      if (consec) begin
         n_vec++; if (last_c - first_c != 3) begin n_err++; $display("FAIL %s_gapless: got span %0d expected 3", tag, last_c - first_c); end
      end
      n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL %s_tail_zero: got %h expected 0", tag, m_if.tdata); end
   endtask

   task automatic test_load_play;
      logic [127:0] exp_w [4];
      bit ok;
      int n_acc;
      exp_w[0] = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
      exp_w[1] = 128'hBBBB_0001_7777_8888_9999_AAAA_BBBB_CCCC;
      exp_w[2] = 128'hCCCC_0002_DDDD_EEEE_FFFF_0123_4567_89AB;
      exp_w[3] = 128'hDDDD_0003_CDEF_FEDC_BA98_7654_3210_0F0F;
      n_acc = 0;
      gpio_write(16'd512, 8'h02);
      for (int i = 0; i < 4; i++) begin
         send(exp_w[i], i == 3, 12, ok);
         n_acc += int'(ok);
      end
      n_vec++; if (n_acc != 4) begin n_err++; $display("FAIL load_accepted: got %0d expected 4", n_acc); end
      gpio_write(16'd512, 8'h00);
      repeat (4) tick;
      gpio_write(16'd512, 8'h01);
      capture(40, 1'b0);
      check_play(exp_w, 1'b1, "play");
      gpio_write(16'd512, 8'h00);
      repeat (4) tick;
      gpio_write(16'd512, 8'h01);
      capture(60, 1'b1);
      check_play(exp_w, 1'b0, "play_bp");
      gpio_write(16'd512, 8'h00);
      repeat (4) tick;
   endtask

   task automatic test_full;
      bit ok;
      int n_acc;
      logic [127:0] exp;
      n_acc = 0;
      gpio_write(16'd512, 8'h02);
      repeat (4) tick;
      n_vec++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL load_ready: got %b expected 1", s_if.tready); end
      strobe(8'h85);
      tick;
      n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL pulse_ignored_in_load: got %h expected 0", m_if.tdata); end
      for (int i = 0; i < 20; i++) begin
         send({4{32'h1000 + 32'(i)}}, 1'b0, 6, ok);
         n_acc += int'(ok);
      end
      n_vec++; if (n_acc != 16) begin n_err++; $display("FAIL full_accepted: got %0d expected 16", n_acc); end
      n_vec++; if (s_if.tready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", s_if.tready); end
      gpio_write(16'd512, 8'h00);
      repeat (4) tick;
      gpio_write(16'd512, 8'h01);
      capture(60, 1'b0);
      n_vec++; if (got.size() != 16) begin n_err++; $display("FAIL full_play_count: got %0d expected 16", got.size()); end
      for (int i = 0; i < 16 && i < got.size(); i++) begin
         exp = {4{32'h1000 + 32'(i)}};
         n_vec++; if (got[i] !== exp) begin n_err++; $display("FAIL full_word%0d: got %h expected %h", i, got[i], exp); end
      end
      n_vec++; if (dones != 1) begin n_err++; $display("FAIL full_done_pulses: got %0d expected 1", dones); end
      gpio_write(16'd512, 8'h00);
      repeat (4) tick;
   endtask

   task automatic test_reset_mid_play;
      bit seen;
      seen = 1'b0;
      gpio_write(16'd512, 8'h01);
      for (int i = 0; i < 20 && !seen; i++) begin
         seen = play_busy;
         if (!seen) tick;
      end
      n_vec++; if (!seen) begin n_err++; $display("FAIL mid_play_start: got busy 0 expected 1"); end
      tick;
      rst = 1'b0;
      #1;
      n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL mid_rst_tdata: got %h expected 0", m_if.tdata); end
      n_vec++; if (play_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", play_busy); end
      n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_tvalid: got %b expected 0", m_if.tvalid); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) tick;
   endtask

   task automatic test_zero_len;
      logic [127:0] exp;
      exp = 128'h7F00;
      gpio_write(16'd512, 8'h01);
      capture(20, 1'b0);
      n_vec++; if (got.size() != 0) begin n_err++; $display("FAIL zero_len_words: got %0d expected 0", got.size()); end
      n_vec++; if (dones != 1) begin n_err++; $display("FAIL zero_len_done: got %0d expected 1", dones); end
      n_vec++; if (busy_seen) begin n_err++; $display("FAIL zero_len_busy: got 1 expected 0"); end
      gpio_write(16'd512, 8'h00);
      repeat (4) tick;
      gpio_write(16'd513, 8'd12);
      repeat (4) tick;
      strobe(8'h7F);
      n_vec++; if (m_if.tdata !== exp) begin n_err++; $display("FAIL shift_saturate: got %h expected %h", m_if.tdata, exp); end
      tick;
      n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL shift_sat_zero: got %h expected 0", m_if.tdata); end
   endtask

   initial begin
      s_if.tdata = '0;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      m_if.tready = 1'b1;
      test_reset;
      test_pulse;
      test_load_play;
      test_full;
      test_reset_mid_play;
      test_zero_len;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
